ped_request_conditioner: RTL
============================

// Module: ped_request_conditioner
// PURPOSE
//  Upstream stage of the intersection light controller. Conditions four raw pedestrian push-buttons:
//  - 2-FF synchronise and debounce each button.
//  - Latch each debounced press into a held request p_e[i] that drives the controller's p_e1..p_e4.
//  - Hold the request until the controller acknowledges it by raising walk signal P[i].
//  Needed because the controller samples requests only on its slow internal tick.
// PARAMETERS
//  N_BTN            4        number of pedestrian channels (bit i = crossing i+1)
//  DEBOUNCE_CYCLES  500000   consecutive stable clk cycles before the clean level changes (10 ms @ 50 MHz)
//  STUCK_CYCLES     250000000  continuous-press limit, used only with PED_STUCK_DETECT_EN (5 s @ 50 MHz)
// PORTS
//  clk          in   1      system clock, same clock that feeds the controller's divider
//  rst_n        in   1      synchronous active-low reset, sampled on posedge clk
//  btn_raw      in   N_BTN  raw, asynchronous, bouncing push-buttons; active-high
//  walk         in   N_BTN  controller walk outputs {P4,P3,P2,P1}; acknowledge; treated as async
//  p_e          out  N_BTN  held pedestrian requests to the controller {p_e4..p_e1}
//  btn_clean    out  N_BTN  debounced button level
//  press_pulse  out  N_BTN  1-cycle strobe on each debounced 0->1 edge
//  btn_stuck    out  N_BTN  stuck-button flag; tied 0 when the feature is compiled out
// BEHAVIOUR
//  Reset (rst_n==0 at posedge clk): all outputs 0, every sync FF 0, debounce counters 0, channel FSMs IDLE.
//  Synchronisers: btn_raw and walk each pass through a 2-FF chain. btn_s/walk_s are the 2nd-stage values.
//  Debounce, per channel:
//  - Counter width $clog2(DEBOUNCE_CYCLES+1).
//  - If btn_s == btn_clean, clear the counter.
//  - Otherwise increment; when the count reaches DEBOUNCE_CYCLES-1, toggle btn_clean and clear the counter.
//  - Any reversion before terminal count restarts from 0; no partial credit.
//  - Latency from a clean raw edge to btn_clean: 2 sync + DEBOUNCE_CYCLES cycles.
//  press_pulse[i]: asserted for exactly one cycle, the cycle after btn_clean[i] rises.
//  walk_rise[i] = walk_s[i] & ~walk_s_d[i]; walk_s_d is one more register stage.
//  Per-channel FSM (2-bit):
//  - IDLE    p_e=0. press_pulse -> PENDING. If walk_s==1 at the same time, -> SERVING instead.
//  - PENDING p_e=1. walk_rise -> SERVING; p_e drops in the same cycle that SERVING is entered.
//            Further presses are absorbed with no counting.
//  - SERVING p_e=0. Presses while walk_s==1 are ignored; that crossing is already being served.
//            When walk_s falls to 0, -> IDLE.
//  - Illegal encoding -> IDLE.
//  Simultaneous events:
//  - press_pulse and walk_rise in the same cycle in IDLE -> SERVING; no request is left behind.
//  - Channels are independent; all four may be PENDING at once.
//  - The controller merges p_e1/p_e2 and p_e3/p_e4 itself; this block does not.
//  Reset mid-operation drops every pending request. The button must be pressed again after release.
//  p_e is a registered output and is glitch-free. It stays level for many slow ticks, so the controller's
//  1 Hz sampling cannot miss it.
// CONFIGURATION
//  PED_STUCK_DETECT_EN defined:
//  - Each channel has a counter of width $clog2(STUCK_CYCLES+1), running while btn_clean==1.
//  - On reaching STUCK_CYCLES-1: btn_stuck[i] sets, and the FSM is forced to IDLE with p_e[i]=0.
//  - While btn_stuck[i]==1, press_pulse[i] is not generated and the FSM ignores the channel.
//  - btn_stuck[i] clears one cycle after btn_clean[i] returns to 0; the counter also clears.
//  - Normal operation resumes on the next press.
//  PED_STUCK_DETECT_EN undefined: no stuck counters; btn_stuck = 0; a held button behaves as one press.
// TESTING (bench parameters: DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
//  1 Bounce: btn_raw[0] toggles 1,0,1 at 1-cycle spacing, then held 1 -> btn_clean[0] rises 2+4 cycles after
//    the last edge; one press_pulse[0]; p_e[0]=1.
//  2 Ack: p_e[1]=1, then walk[1] rises -> p_e[1]=0 within 3 cycles (2 sync + 1). Press during walk=1 ->
//    p_e[1] stays 0. walk falls, press again -> p_e[1]=1.
//  3 Simultaneous: press_pulse[2] in the same cycle as walk_rise[2] -> p_e[2] never asserts; FSM goes to SERVING.
//  4 Reset mid-request: p_e=4'b1011, rst_n=0 for 1 cycle -> all outputs 0 next cycle; held buttons must be
//    released and re-pressed.
//  5 Independence: buttons 0 and 3 pressed, walk[0] only -> p_e=4'b1000.
//  6 (PED_STUCK_DETECT_EN) Hold btn_raw[1]=1 for 30 cycles -> btn_stuck[1]=1 and p_e[1]=0 once held 20 cycles
//    after btn_clean. Release -> btn_stuck[1]=0; next press -> p_e[1]=1. Without the macro, btn_stuck=0 throughout.

Source files
------------

// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_conditioner
// Description : Pedestrian push-button front end for the intersection light
//               controller. Each channel synchronises its raw button, debounces
//               it, turns each debounced press into a request held on p_e[i],
//               and drops the request once the controller answers with walk[i].
//               The request is held as a level because the controller only
//               samples it on its slow internal tick.
//
// Ports       : clk          system clock, shared with the controller divider
//               rst_n        synchronous active-low reset
//               btn_raw      raw asynchronous active-high push-buttons
//               walk         controller walk outputs {P4..P1}, used as acknowledge
//               p_e          held pedestrian requests {p_e4..p_e1}, registered
//               btn_clean    debounced button level
//               press_pulse  one-cycle strobe the cycle after btn_clean rises
//               btn_stuck    stuck-button flag (0 unless detection is built in)
//
// Build macro : PED_STUCK_DETECT_EN - adds per-channel continuous-press
//               detection; a button held for STUCK_CYCLES is flagged stuck and
//               its channel is parked until the button is released.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STUCK_CYCLES    = 250000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] walk,
    output logic [N_BTN-1:0] p_e,
    output logic [N_BTN-1:0] btn_clean,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] btn_stuck
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_TERM = c_DB_W'(DEBOUNCE_CYCLES - 1);

    // Channel request FSM encoding
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PENDING = 2'd1;
    localparam logic [1:0] c_SERVING = 2'd2;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers for buttons and walk; walk gets a third stage so
    // its rising edge can be detected on synchronised data.
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] r_btn_meta;
    logic [N_BTN-1:0] r_btn_s;
    logic [N_BTN-1:0] r_walk_meta;
    logic [N_BTN-1:0] r_walk_s;
    logic [N_BTN-1:0] r_walk_s_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_meta  <= '0;
            r_btn_s     <= '0;
            r_walk_meta <= '0;
            r_walk_s    <= '0;
            r_walk_s_d  <= '0;
        end else begin
            r_btn_meta  <= btn_raw;
            r_btn_s     <= r_btn_meta;
            r_walk_meta <= walk;
            r_walk_s    <= r_walk_meta;
            r_walk_s_d  <= r_walk_s;
        end
    end

`ifndef PED_STUCK_DETECT_EN
    // STUCK_CYCLES has no consumer when detection is compiled out; this empty,
    // never-elaborated block keeps the parameter referenced so both builds
    // share one parameter list.
    if (STUCK_CYCLES < 0) begin : g_stuck_cfg_unused
    end
`endif

    genvar i;
    generate
        for (i = 0; i < N_BTN; i++) begin : g_chan
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_clean;
            logic              r_clean_d;
            logic              r_press;
            logic              r_pe;
            logic [1:0]        r_state;
            logic [1:0]        w_state_nxt;
            logic              w_walk_rise;
            logic              w_stuck;
            logic              w_block;

            assign w_walk_rise = r_walk_s[i] & ~r_walk_s_d[i];

            // Debounce: the clean level only moves after DEBOUNCE_CYCLES
            // consecutive disagreeing samples; any agreement restarts the count.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_db_cnt <= '0;
                    r_clean  <= 1'b0;
                end else if (r_btn_s[i] == r_clean) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_TERM) begin
                    r_clean  <= ~r_clean;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            // Press strobe lands the cycle after the clean level rises.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_clean_d <= 1'b0;
                    r_press   <= 1'b0;
                end else begin
                    r_clean_d <= r_clean;
                    r_press   <= r_clean & ~r_clean_d & ~w_stuck;
                end
            end

`ifdef PED_STUCK_DETECT_EN
            localparam int                c_ST_W    = $clog2(STUCK_CYCLES + 1);
            localparam logic [c_ST_W-1:0] c_ST_TERM = c_ST_W'(STUCK_CYCLES - 1);

            logic [c_ST_W-1:0] r_st_cnt;
            logic              r_stuck;
            logic              w_stuck_hit;

            assign w_stuck_hit = r_clean & ~r_stuck & (r_st_cnt == c_ST_TERM);

            // Counts while the clean level is high; the flag and count both
            // clear on the first cycle the clean level is back at 0.
            always_ff @(posedge clk) begin
                if (!rst_n || !r_clean) begin
                    r_st_cnt <= '0;
                    r_stuck  <= 1'b0;
                end else if (w_stuck_hit) begin
                    r_stuck  <= 1'b1;
                end else if (!r_stuck) begin
                    r_st_cnt <= r_st_cnt + 1'b1;
                end
            end

            assign w_stuck = r_stuck;
            // Park the channel both on the cycle the limit is hit and while flagged.
            assign w_block = w_stuck_hit | r_stuck;
`else
            assign w_stuck = 1'b0;
            assign w_block = 1'b0;
`endif

            // Request FSM: next-state logic
            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_IDLE: begin
                        // A press arriving while walk is already up is served
                        // immediately, so no request is left behind.
                        if (r_press) begin
                            w_state_nxt = r_walk_s[i] ? c_SERVING : c_PENDING;
                        end
                    end
                    c_PENDING: begin
                        if (w_walk_rise) begin
                            w_state_nxt = c_SERVING;
                        end
                    end
                    c_SERVING: begin
                        if (!r_walk_s[i]) begin
                            w_state_nxt = c_IDLE;
                        end
                    end
                    default: w_state_nxt = c_IDLE;
                endcase
                if (w_block) begin
                    w_state_nxt = c_IDLE;
                end
            end

            // Request FSM: state register. p_e is registered from the next
            // state so it changes on the same edge as the state and never glitches.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state <= c_IDLE;
                    r_pe    <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_pe    <= (w_state_nxt == c_PENDING);
                end
            end

            assign p_e[i]         = r_pe;
            assign btn_clean[i]   = r_clean;
            assign press_pulse[i] = r_press;
            assign btn_stuck[i]   = w_stuck;
        end
    endgenerate

endmodule
`default_nettype wire
